// File: rtl/tile_window_buffer_pkg.sv
// rtl/tile_window_buffer_pkg.sv - shared defaults, derived constants and bank-state encoding
// Purpose: parameter defaults for the ping-pong 3x3 window buffer, the derived
// beat/output-grid constants at those defaults, and the per-bank state type.
// Ports: none (package).
package tile_window_buffer_pkg;

    localparam int PIX_W_DEF = 5;
    localparam int LANES_DEF = 5;
    localparam int TILE_DEF  = 20;
    localparam int CNT_W_DEF = 9;

    // Beats per tile and windows per side at the default geometry.
    localparam int BEATS = TILE_DEF * TILE_DEF / LANES_DEF;
    localparam int OUT   = TILE_DEF - 2;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/tile_bank.sv
// rtl/tile_bank.sv - one TILE x TILE pixel store with lane-wide write and 3x3 window read
// Purpose: register array holding one tile, written LANES pixels per beat in
// row-major order and read as the 3x3 window anchored at (rrow_i, rcol_i).
// Ports:
//   clk      - rising-edge clock
//   we_i     - write strobe for the beat on wdata_i
//   wbeat_i  - beat number; lane l lands at pixel wbeat_i*LANES+l
//   wdata_i  - LANES pixels, lane l in bits [l*PIX_W +: PIX_W]
//   rrow_i   - window top row
//   rcol_i   - window left column
//   win_o    - window pixel k=dr*3+dc in bits [k*PIX_W +: PIX_W]
module tile_bank #(
    parameter int PIX_W = 5,
    parameter int LANES = 5,
    parameter int TILE  = 20,
    parameter int CNT_W = 9
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [CNT_W-1:0]       wbeat_i,
    input  logic [LANES*PIX_W-1:0] wdata_i,
    input  logic [CNT_W-1:0]       rrow_i,
    input  logic [CNT_W-1:0]       rcol_i,
    output logic [9*PIX_W-1:0]     win_o
);

    localparam int DEPTH = TILE * TILE;
    localparam int AW    = $clog2(DEPTH);

    // Pixel data needs no reset: the owning bank FSM decides whether it is valid.
    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wbase;
    logic [AW-1:0]    rbase;

    assign wbase = AW'(wbeat_i) * AW'(LANES);
    assign rbase = AW'(rrow_i) * AW'(TILE) + AW'(rcol_i);

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                mem_q[wbase + AW'(l)] <= wdata_i[l*PIX_W +: PIX_W];
            end
        end
    end

    always_comb begin
        win_o = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                win_o[(dr*3+dc)*PIX_W +: PIX_W] = mem_q[rbase + AW'(dr*TILE + dc)];
            end
        end
    end

endmodule

// File: rtl/tile_window_buffer.sv
// rtl/tile_window_buffer.sv - ping-pong tile loader streaming interior 3x3 windows
// Purpose: loads a tile into bank wbank while the other bank (rbank) streams
// every interior 3x3 window row-major to the filter pipeline.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   flush      - synchronous discard of both banks and all counters
//   in_valid / in_ready / pixel_in / in_last - input beat handshake, LANES pixels
//   out_valid / out_ready / win_out          - window handshake, 9 pixels
//   out_row / out_col - window position; out_last - window (OUT-1, OUT-1)
//   bank_full  - number of banks holding an undrained tile
//   err        - sticky in_last / beat-count mismatch
module tile_window_buffer
    import tile_window_buffer_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int LANES = LANES_DEF,
    parameter int TILE  = TILE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] pixel_in,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [9*PIX_W-1:0]     win_out,
    output logic [CNT_W-1:0]       out_row,
    output logic [CNT_W-1:0]       out_col,
    output logic                   out_last,
    output logic [1:0]             bank_full,
    output logic                   err
);

    localparam int N_BEATS = TILE * TILE / LANES;
    localparam int N_OUT   = TILE - 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(N_OUT - 1);

    if ((TILE * TILE) % LANES != 0) begin : g_bad_lanes
        $error("tile_window_buffer: TILE*TILE must be divisible by LANES");
    end

    bank_state_e            st_q [2];
    bank_state_e            st_d [2];
    logic                   wbank_q, wbank_d;
    logic                   rbank_q, rbank_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [CNT_W-1:0]       row_q, row_d;
    logic [CNT_W-1:0]       col_q, col_d;
    logic                   err_q, err_d;
    logic [9*PIX_W-1:0]     win_bank [2];
    logic                   wr_fire, rd_fire, beat_final, win_final;

    // A FULL write bank refuses beats, so a bank is never written and read together.
    assign in_ready   = (st_q[wbank_q] != BANK_FULL);
    assign out_valid  = (st_q[rbank_q] == BANK_FULL);
    assign wr_fire    = in_valid && in_ready;
    assign rd_fire    = out_valid && out_ready;
    assign beat_final = (beat_q == LAST_BEAT);
    assign win_final  = (row_q == LAST_POS) && (col_q == LAST_POS);

    assign win_out   = out_valid ? win_bank[rbank_q] : '0;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = out_valid && win_final;
    assign err       = err_q;
    assign bank_full = 2'(st_q[0] == BANK_FULL) + 2'(st_q[1] == BANK_FULL);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        tile_bank #(
            .PIX_W(PIX_W),
            .LANES(LANES),
            .TILE (TILE),
            .CNT_W(CNT_W)
        ) u_bank (
            .clk    (clk),
            .we_i   (wr_fire && (wbank_q == 1'(g))),
            .wbeat_i(beat_q),
            .wdata_i(pixel_in),
            .rrow_i (row_q),
            .rcol_i (col_q),
            .win_o  (win_bank[g])
        );
    end

    always_comb begin
        st_d    = st_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        beat_d  = beat_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = err_q;

        if (wr_fire) begin
            st_d[wbank_q] = beat_final ? BANK_FULL : BANK_FILLING;
            beat_d        = beat_final ? '0 : beat_q + 1'b1;
            if (beat_final) begin
                wbank_d = ~wbank_q;
            end
            // in_last is only checked, never used to steer the data flow.
            if (in_last != beat_final) begin
                err_d = 1'b1;
            end
        end

        if (rd_fire) begin
            if (win_final) begin
                st_d[rbank_q] = BANK_EMPTY;
                rbank_d       = ~rbank_q;
                row_d         = '0;
                col_d         = '0;
            end else if (col_q == LAST_POS) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (flush) begin
            st_d[0] = BANK_EMPTY;
            st_d[1] = BANK_EMPTY;
            wbank_d = 1'b0;
            rbank_d = 1'b0;
            beat_d  = '0;
            row_d   = '0;
            col_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q[0] <= BANK_EMPTY;
            st_q[1] <= BANK_EMPTY;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            beat_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/tile_window_buffer.md
Name: tile_window_buffer

Overview:
- Parametrised successor to the fixed 5-lane, 20x20 tile input stage of the edge-detection CHIP.
- Accepts a tile as LANES pixels per beat into one of two ping-pong banks. Streams every interior 3x3 window of the other bank to the filter pipeline.
- Loading tile N+1 overlaps draining tile N, so the front end no longer pauses input during readout.
- Sits between the pixel input pads and the smoothing/gradient stage.

Parameters:
- PIX_W, 5, bits per pixel.
- LANES, 5, pixels accepted per input beat; TILE*TILE must be divisible by LANES (elaboration error otherwise).
- TILE, 20, tile edge length in pixels; output grid OUT = TILE-2 per side.
- CNT_W, 9, width of the beat, row and column counters; must hold TILE*TILE/LANES-1 and OUT-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- flush  in  1  synchronous; discards both banks and all counters.
- in_valid  in  1  input beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- pixel_in  in  LANES*PIX_W  lane l in bits [l*PIX_W +: PIX_W].
- in_last  in  1  producer marks the final beat of a tile.
- out_valid  out  1  window present.
- out_ready  in  1  window consumed when out_valid && out_ready.
- win_out  out  9*PIX_W  window pixel k = dr*3+dc in bits [k*PIX_W +: PIX_W].
- out_row, out_col  out  CNT_W each  window position, 0..OUT-1.
- out_last  out  1  high with the window at (OUT-1, OUT-1).
- bank_full  out  2  number of banks holding an undrained tile, 0..2.
- err  out  1  sticky in_last/beat-count mismatch.

Behaviour:
- Reset values: in_ready=1 once reset deasserts. out_valid=0, win_out=0, out_row=0, out_col=0, out_last=0, bank_full=0, err=0. Both banks EMPTY, wbank=0, rbank=0.
- Bank state machine, one per bank: EMPTY -> FILLING on the first accepted beat; FILLING -> FULL on the accepted beat TILE*TILE/LANES-1; FULL -> EMPTY on acceptance of the window flagged out_last.
- Write side:
  - Beat b writes pixel index b*LANES+l, row-major, to bank wbank.
  - in_ready = state(wbank) is EMPTY or FILLING.
  - On the final beat, the beat counter wraps to 0 and wbank toggles.
- Read side:
  - out_valid = state(rbank)==FULL.
  - win_out pixel (dr,dc) = bank[rbank][(out_row+dr)*TILE + out_col+dc].
  - Windows are emitted row-major. On acceptance, out_col increments; at OUT-1 it wraps to 0 and out_row increments. On the out_last acceptance both counters clear and rbank toggles.
- Latency: out_valid rises in the cycle after the final input beat is accepted. Under continuous out_ready, one window is produced per cycle: OUT*OUT cycles per tile (324 at defaults).
- Backpressure: while out_valid && !out_ready, win_out, out_row, out_col and out_last hold stable.
- Simultaneous events:
  - Final write into one bank and last window read from the other in the same cycle: both transitions take effect, and bank_full is unchanged.
  - A write and a read to different banks never conflict. The same bank is never written and read at once, because a FULL bank refuses writes.
- in_last handling:
  - If in_last is high on any accepted beat other than the final one, or low on the final one, err sets and stays set until reset or flush.
  - Data flow itself is governed by the beat counter only.
- flush takes effect on the next edge and has priority over in_valid/out_ready in that cycle. Afterwards the state equals the reset state.
- Reset asserted mid-load or mid-drain: immediate return to the reset state; partial tiles are lost.

Decomposition:
- Shared package: PIX_W and TILE defaults, the derived constants BEATS=TILE*TILE/LANES and OUT=TILE-2, and the bank-state encoding (EMPTY, FILLING, FULL).
- One sub-module, tile_bank: a single TILE*TILE x PIX_W register array with a LANES-wide write port and a 9-pixel window read port. It is instantiated twice; the top holds counters, bank FSMs and muxing.

Test Plan:
- Single tile, pixel value = index mod 32, out_ready=1: out_valid rises 1 cycle after beat 80. First window = 0,1,2,20,21,22,8,9,10. 324 windows are emitted, with out_last only on (17,17), and bank_full goes 1 -> 0.
- Three tiles back-to-back, in_valid held high: in_ready stays 1 for 160 beats, then drops. It returns high the cycle after tile 0's out_last is accepted. Output windows match tiles 0, 1 and 2 in order, with bank_full peaking at 2.
- Random out_ready (50% duty) on one tile: win_out, out_row and out_col are stable on every stalled cycle, and the window sequence is identical to the out_ready=1 case.
- flush at beat 40 of tile 0: out_valid never rises and bank_full=0. The next tile loads from index 0 and drains correctly.
- reset pulse at window 100 of a drain: all outputs are 0 and in_ready=1 after release. A fresh tile reproduces scenario 1.
- in_last asserted on beat 79 of 80: err=1 and persists across the next tile. The tile's data is still output correctly.
